// File: rtl/cv32e40p_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_rf_wb_arbiter
// Description : Register-file writeback arbiter. The ALU always owns write
//               port A and the LSU always owns write port B. Multi-cycle
//               results (mult/div/FPU) go into a small FIFO and drain into
//               whichever port is idle. A buffered head that is overwritten
//               by a same-cycle direct write is dropped.
//               Optional macro CV32E40P_RF_WB_FWD_EN: when the buffer is empty
//               and a port is free, an accepted multi-cycle result bypasses
//               the FIFO and is written in the cycle it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_rf_wb_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid_i,
   input  logic [ADDR_WIDTH-1:0] alu_addr_i,
   input  logic [DATA_WIDTH-1:0] alu_data_i,
   input  logic                  lsu_valid_i,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0] lsu_data_i,
   input  logic                  mc_valid_i,
   output logic                  mc_ready_o,
   input  logic [ADDR_WIDTH-1:0] mc_addr_i,
   input  logic [DATA_WIDTH-1:0] mc_data_i,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_a_o,
   output logic [ADDR_WIDTH-1:0] waddr_b_o,
   output logic [DATA_WIDTH-1:0] wdata_b_o,
   output logic                  we_b_o,
   output logic                  mc_superseded_o,
   output logic                  wb_busy_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // Buffer storage (data path only, no reset needed)
   logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
   logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
   logic                  we_a_q, we_a_d;
   logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
   logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
   logic                  we_b_q, we_b_d;
   logic                  sup_q, sup_d;

   logic                  head_valid;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_hit;
   logic                  mc_hit;
   logic                  mc_hs;
   logic                  deq;
   logic                  enq;

   // Ready depends only on the registered count; forced low during reset
   assign mc_ready_o = rst_n & (cnt_q < DEPTH_C);
   assign mc_hs      = mc_valid_i & mc_ready_o;

   assign head_valid = (cnt_q != '0);
   assign head_addr  = fifo_addr_q[rptr_q];
   assign head_data  = fifo_data_q[rptr_q];

   // A direct write to the same register is newer than the buffered result
   assign head_hit = (alu_valid_i && (alu_addr_i == head_addr)) ||
                     (lsu_valid_i && (lsu_addr_i == head_addr));
   assign mc_hit   = (alu_valid_i && (alu_addr_i == mc_addr_i)) ||
                     (lsu_valid_i && (lsu_addr_i == mc_addr_i));

   // Port arbitration: direct sources first, then buffer head / bypass
   always_comb begin
      we_a_d    = alu_valid_i && (alu_addr_i != '0);
      waddr_a_d = alu_addr_i;
      wdata_a_d = alu_data_i;
      we_b_d    = lsu_valid_i && (lsu_addr_i != '0);
      waddr_b_d = lsu_addr_i;
      wdata_b_d = lsu_data_i;
      sup_d     = 1'b0;
      deq       = 1'b0;
      enq       = 1'b0;

      // Buffered head never holds address 0 (those are discarded on accept)
      if (head_valid) begin
         if (head_hit) begin
            deq   = 1'b1;
            sup_d = 1'b1;
         end else if (!alu_valid_i) begin
            deq       = 1'b1;
            we_a_d    = 1'b1;
            waddr_a_d = head_addr;
            wdata_a_d = head_data;
         end else if (!lsu_valid_i) begin
            deq       = 1'b1;
            we_b_d    = 1'b1;
            waddr_b_d = head_addr;
            wdata_b_d = head_data;
         end
      end

      if (mc_hs && (mc_addr_i != '0)) begin
`ifdef CV32E40P_RF_WB_FWD_EN
         if (!head_valid && (!alu_valid_i || !lsu_valid_i)) begin
            if (mc_hit) begin
               sup_d = 1'b1;
            end else if (!alu_valid_i) begin
               we_a_d    = 1'b1;
               waddr_a_d = mc_addr_i;
               wdata_a_d = mc_data_i;
            end else begin
               we_b_d    = 1'b1;
               waddr_b_d = mc_addr_i;
               wdata_b_d = mc_data_i;
            end
         end else begin
            enq = 1'b1;
         end
`else
         enq = 1'b1;
`endif
      end

      rptr_d = rptr_q + PTR_W'(deq);
      wptr_d = wptr_q + PTR_W'(enq);
      cnt_d  = cnt_q + CNT_W'(enq) - CNT_W'(deq);
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr_q    <= '0;
         wptr_q    <= '0;
         cnt_q     <= '0;
         waddr_a_q <= '0;
         wdata_a_q <= '0;
         we_a_q    <= 1'b0;
         waddr_b_q <= '0;
         wdata_b_q <= '0;
         we_b_q    <= 1'b0;
         sup_q     <= 1'b0;
      end else begin
         rptr_q    <= rptr_d;
         wptr_q    <= wptr_d;
         cnt_q     <= cnt_d;
         waddr_a_q <= waddr_a_d;
         wdata_a_q <= wdata_a_d;
         we_a_q    <= we_a_d;
         waddr_b_q <= waddr_b_d;
         wdata_b_q <= wdata_b_d;
         we_b_q    <= we_b_d;
         sup_q     <= sup_d;
      end
   end

   // Buffer write on accepted, non-bypassed, non-zero-address requests
   always_ff @(posedge clk) begin
      if (rst_n && enq) begin
         fifo_addr_q[wptr_q] <= mc_addr_i;
         fifo_data_q[wptr_q] <= mc_data_i;
      end
   end

   assign waddr_a_o       = waddr_a_q;
   assign wdata_a_o       = wdata_a_q;
   assign we_a_o          = we_a_q;
   assign waddr_b_o       = waddr_b_q;
   assign wdata_b_o       = wdata_b_q;
   assign we_b_o          = we_b_q;
   assign mc_superseded_o = sup_q;
   assign wb_busy_o       = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_rf_wb_arbiter
// Description : Scoreboard bench for the writeback arbiter. Each stimulus
//               cycle pushes the expected post-edge state, computed from a
//               queue-based reference model; a monitor pops and compares.
//               Follows CV32E40P_RF_WB_FWD_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_rf_wb_arbiter;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid_i = 1'b0;
   logic [AW-1:0] alu_addr_i = '0;
   logic [DW-1:0] alu_data_i = '0;
   logic          lsu_valid_i = 1'b0;
   logic [AW-1:0] lsu_addr_i = '0;
   logic [DW-1:0] lsu_data_i = '0;
   logic          mc_valid_i = 1'b0;
   logic          mc_ready_o;
   logic [AW-1:0] mc_addr_i = '0;
   logic [DW-1:0] mc_data_i = '0;
   logic [AW-1:0] waddr_a_o;
   logic [DW-1:0] wdata_a_o;
   logic          we_a_o;
   logic [AW-1:0] waddr_b_o;
   logic [DW-1:0] wdata_b_o;
   logic          we_b_o;
   logic          mc_superseded_o;
   logic          wb_busy_o;

   cv32e40p_rf_wb_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_valid_i     (alu_valid_i),
      .alu_addr_i      (alu_addr_i),
      .alu_data_i      (alu_data_i),
      .lsu_valid_i     (lsu_valid_i),
      .lsu_addr_i      (lsu_addr_i),
      .lsu_data_i      (lsu_data_i),
      .mc_valid_i      (mc_valid_i),
      .mc_ready_o      (mc_ready_o),
      .mc_addr_i       (mc_addr_i),
      .mc_data_i       (mc_data_i),
      .waddr_a_o       (waddr_a_o),
      .wdata_a_o       (wdata_a_o),
      .we_a_o          (we_a_o),
      .waddr_b_o       (waddr_b_o),
      .wdata_b_o       (wdata_b_o),
      .we_b_o          (we_b_o),
      .mc_superseded_o (mc_superseded_o),
      .wb_busy_o       (wb_busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   typedef struct {
      bit            rst;
      bit            we_a;
      logic [AW-1:0] wa;
      logic [DW-1:0] da;
      bit            we_b;
      logic [AW-1:0] wb;
      logic [DW-1:0] db;
      bit            sup;
      bit            rdy;
      bit            busy;
   } exp_t;

   ent_t mq[$];     // reference model of buffered results, oldest first
   exp_t exp_q[$];  // expected post-edge observations

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Apply one cycle of stimulus and record what the model expects after the edge
   task automatic step(input bit rst, input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
      exp_t e;
      ent_t h;
      bit   empty0, hs, bypass;
      @(negedge clk);
      rst_n = ~rst; alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
      lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
      mc_valid_i = mv; mc_addr_i = ma; mc_data_i = md;
      e = '{default: '0};
      e.rst = rst;
      if (rst) begin
         mq.delete();
      end else begin
         hs     = mv && (mq.size() < DEPTH);
         empty0 = (mq.size() == 0);
         if (av && aa != 0) begin e.we_a = 1; e.wa = aa; e.da = ad; end
         if (lv && la != 0) begin e.we_b = 1; e.wb = la; e.db = ld; end
         if (!empty0) begin
            h = mq[0];
            if ((av && aa == h.a) || (lv && la == h.a)) begin
               void'(mq.pop_front()); e.sup = 1;
            end else if (!av) begin
               void'(mq.pop_front()); e.we_a = 1; e.wa = h.a; e.da = h.d;
            end else if (!lv) begin
               void'(mq.pop_front()); e.we_b = 1; e.wb = h.a; e.db = h.d;
            end
         end
         if (hs && ma != 0) begin
            bypass = 0;
`ifdef CV32E40P_RF_WB_FWD_EN
            bypass = empty0 && (!av || !lv);
`endif
            if (bypass) begin
               if ((av && aa == ma) || (lv && la == ma)) e.sup = 1;
               else if (!av) begin e.we_a = 1; e.wa = ma; e.da = md; end
               else begin e.we_b = 1; e.wb = ma; e.db = md; end
            end else begin
               mq.push_back('{a: ma, d: md});
            end
         end
         e.rdy  = (mq.size() < DEPTH);
         e.busy = (mq.size() != 0);
      end
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare DUT state shortly after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("we_a", DW'(we_a_o), DW'(e.we_a));
            chk("we_b", DW'(we_b_o), DW'(e.we_b));
            chk("superseded", DW'(mc_superseded_o), DW'(e.sup));
            chk("mc_ready", DW'(mc_ready_o), DW'(e.rdy));
            chk("wb_busy", DW'(wb_busy_o), DW'(e.busy));
            if (e.we_a || e.rst) begin
               chk("waddr_a", DW'(waddr_a_o), DW'(e.wa));
               chk("wdata_a", wdata_a_o, e.da);
            end
            if (e.we_b || e.rst) begin
               chk("waddr_b", DW'(waddr_b_o), DW'(e.wb));
               chk("wdata_b", wdata_b_o, e.db);
            end
         end
      end
   end

   function automatic logic [AW-1:0] rnd_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 3));
      a[5] = 1'($urandom_range(0, 1));
      return a;
   endfunction

   initial begin
      int wait_cycles;
      // Reset
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      // Plain ALU write
      step(0, 1, 6'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      // mc result buffered behind busy ALU/LSU, then drains when idle
      step(0, 1, 6'd1, 32'h11, 1, 6'd2, 32'h22, 1, 6'd33, 32'h1);
      idle();
      idle();
      // Fill the buffer and hold both ports busy
      step(0, 1, 6'd1, 32'hA1, 1, 6'd2, 32'hB1, 1, 6'd7, 32'h77);
      step(0, 1, 6'd1, 32'hA2, 1, 6'd2, 32'hB2, 1, 6'd8, 32'h88);
      step(0, 1, 6'd1, 32'hA3, 1, 6'd2, 32'hB3, 1, 6'd9, 32'h99);
      step(0, 1, 6'd3, 32'hA4, 1, 6'd4, 32'hB4, 0, 0, 0);
      // ALU overwrites the buffered head (addr 7)
      step(0, 1, 6'd7, 32'hC7, 1, 6'd3, 32'hC3, 0, 0, 0);
      // Address 0 from every source
      step(0, 1, 6'd0, 32'h1234, 1, 6'd0, 32'h5678, 1, 6'd0, 32'h9ABC);
      idle();
      idle();
      // Reset while holding two buffered entries
      step(0, 1, 6'd1, 32'h1, 1, 6'd2, 32'h2, 1, 6'd10, 32'hAA);
      step(0, 1, 6'd1, 32'h1, 1, 6'd2, 32'h2, 1, 6'd11, 32'hBB);
      step(1, 1, 6'd1, 32'h1, 1, 6'd2, 32'h2, 0, 0, 0);
      idle();
      idle();
      // mc latency with empty buffer and free ports
      step(0, 0, 0, 0, 0, 0, 0, 1, 6'd9, 32'h5A5A5A5A);
      idle();
      idle();
      step(0, 1, 6'd4, 32'h44, 0, 0, 0, 1, 6'd12, 32'hCC);
      idle();
      idle();
      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
              1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
              1'($urandom_range(0, 1)), rnd_addr(), $urandom());
      end
      for (int i = 0; i < 4; i++) idle();
      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #5;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
